avalon_mem_responder: RTL and testbench

Avalon-MM responder (slave) that terminates the data-side Avalon initiator port of the ibex Avalon wrapper. It is word-addressed, matching the wrapper's {2'b0, addr[31:2]} address convention. It backs a parameterised internal word memory, injects programmable waitrequest stalls, and returns pipelined reads at a fixed latency with an Avalon response code. It serves as the simulation and FPGA memory model for the core's main bus.

---
 rtl/avalon_pkg.sv | 37 +++
 rtl/avalon_read_pipe.sv | 45 ++++
 rtl/avalon_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_avalon_mem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_pkg
// Description : Shared types for the Avalon-MM memory responder: response
//               codes, read-pipeline stage record and stall FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_pkg;

    localparam int c_data_w = 32;
    localparam int c_be_w   = 4;

    // Avalon response codes
    typedef enum logic [1:0] {
        OKAY        = 2'b00,
        RESERVED    = 2'b01,
        SLAVEERROR  = 2'b10,
        DECODEERROR = 2'b11
    } resp_e;

    // One slot of the read-return pipeline
    typedef struct packed {
        logic                valid;
        logic [c_data_w-1:0] data;
        resp_e               resp;
    } rd_stage_t;

    // Waitrequest stall FSM
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    localparam rd_stage_t c_rd_empty = '{valid: 1'b0, data: '0, resp: OKAY};

endpackage : avalon_pkg
`default_nettype wire

// File: rtl/avalon_read_pipe.sv
`default_nettype none
// ============================================================================
// Module      : avalon_read_pipe
// Description : Fixed-latency shift register carrying read results from the
//               acceptance cycle to the readdatavalid cycle, in order.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_read_pipe
    import avalon_pkg::*;
#(
    parameter int ReadLatency = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  rd_stage_t stage_in,
    output rd_stage_t stage_out
);

    // Latency outside 1..8 is not a supported configuration
    generate
        if ((ReadLatency < 1) || (ReadLatency > 8)) begin : g_bad_latency
            $error("avalon_read_pipe: ReadLatency must be in 1..8");
        end
    endgenerate

    rd_stage_t r_stage [ReadLatency];

    // Shift results one slot per cycle; reset discards everything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ReadLatency; i++) begin
                r_stage[i] <= c_rd_empty;
            end
        end else begin
            r_stage[0] <= stage_in;
            for (int i = 1; i < ReadLatency; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign stage_out = r_stage[ReadLatency-1];

endmodule : avalon_read_pipe
`default_nettype wire

// File: rtl/avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : avalon_mem_responder
// Description : Word-addressed Avalon-MM responder backed by an internal
//               32-bit memory, with programmable waitrequest stalls,
//               fixed-latency pipelined reads and a sticky protocol flag.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int AddrWidth   = 32,
    parameter int MemWords    = 1024,
    parameter int ReadLatency = 2,
    parameter int StallCycles = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] avs_address,
    input  logic [c_be_w-1:0]    avs_byteenable,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [c_data_w-1:0]  avs_writedata,
    output logic                 avs_waitrequest,
    output logic [c_data_w-1:0]  avs_readdata,
    output logic                 avs_readdatavalid,
    output logic [1:0]           avs_response,
    output logic                 protocol_err_o
);

    localparam int c_cnt_w = (StallCycles > 0) ? $clog2(StallCycles + 1) : 1;
    localparam int c_idx_w = (MemWords > 1) ? $clog2(MemWords) : 1;

    localparam logic [c_cnt_w-1:0]   c_stall_max = c_cnt_w'(StallCycles);
    localparam logic [AddrWidth:0]   c_mem_words = (AddrWidth + 1)'(MemWords);

    logic [c_data_w-1:0] r_mem [MemWords];

    stall_state_e        r_state;
    stall_state_e        w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                w_drop_err;
    logic                r_protocol_err;

    logic                w_cmd;
    logic                w_wait;
    logic                w_accept;
    logic                w_wr_accept;
    logic                w_rd_accept;
    logic                w_in_range;
    logic [c_idx_w-1:0]  w_idx;
    rd_stage_t           w_rd_stage;
    rd_stage_t           w_pipe_out;

    assign w_cmd = avs_read | avs_write;

    // Address compared at full width plus one bit so MemWords == 2**AddrWidth
    // still works; no aliasing of out-of-range addresses onto the array.
    assign w_in_range = ({1'b0, avs_address} < c_mem_words);
    assign w_idx      = avs_address[c_idx_w-1:0];

    // Held off until the stall count is reached; quiet while in reset
    assign w_wait      = w_cmd && (r_cnt != c_stall_max) && !rst_i;
    assign w_accept    = w_cmd && !w_wait && !rst_i;
    assign w_wr_accept = w_accept && avs_write;
    // A simultaneous read+write only performs the write
    assign w_rd_accept = w_accept && avs_read && !avs_write;

    // Stall FSM state and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stall FSM next-state: count waitrequest cycles, release at StallCycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_drop_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd && (StallCycles > 0)) begin
                    w_state_nxt = ST_STALL;
                    w_cnt_nxt   = c_cnt_w'(1);
                end
            end
            ST_STALL: begin
                if (!w_cmd) begin
                    // Master withdrew a command while it was being stalled
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_drop_err  = 1'b1;
                end else if (r_cnt == c_stall_max) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Byte-lane writes into the memory; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_wr_accept && w_in_range) begin
            for (int i = 0; i < c_be_w; i++) begin
                if (avs_byteenable[i]) begin
                    r_mem[w_idx][8*i +: 8] <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    // Build the pipeline entry for an accepted read (sees earlier writes)
    always_comb begin
        w_rd_stage       = c_rd_empty;
        w_rd_stage.valid = w_rd_accept;
        if (w_rd_accept) begin
            if (w_in_range) begin
                w_rd_stage.data = r_mem[w_idx];
                w_rd_stage.resp = OKAY;
            end else begin
                w_rd_stage.data = '0;
                w_rd_stage.resp = SLAVEERROR;
            end
        end
    end

    avalon_read_pipe #(
        .ReadLatency (ReadLatency)
    ) u_read_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stage_in  (w_rd_stage),
        .stage_out (w_pipe_out)
    );

    // Sticky protocol flag: dual read/write or a command dropped mid-stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_protocol_err <= 1'b0;
        end else if (w_drop_err || (avs_read && avs_write)) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign avs_waitrequest   = w_wait;
    assign avs_readdatavalid = w_pipe_out.valid;
    assign avs_readdata      = w_pipe_out.valid ? w_pipe_out.data : '0;
    assign avs_response      = w_pipe_out.valid ? w_pipe_out.resp : OKAY;
    assign protocol_err_o    = r_protocol_err;

endmodule : avalon_mem_responder
`default_nettype wire

// File: tb/tb_avalon_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_mem_responder
// Description : Self-checking bench: a zero-stall instance and a three-stall
//               instance, with a scoreboard of expected read returns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;

    // Zero-stall instance
    logic [31:0] addr0, wd0, rdata0;
    logic [3:0]  be0;
    logic        rd0, wr0, wait0, rdv0, perr0;
    logic [1:0]  resp0;

    // Three-stall instance
    logic [31:0] addrs, wds, rdatas;
    logic [3:0]  bes;
    logic        rds, wrs, waits, rdvs, perrs;
    logic [1:0]  resps;

    exp_t        q0[$];
    exp_t        qs[$];
    logic [31:0] ref0 [1024];
    logic [31:0] refs [1024];
    int          cyc;
    int          n_cmp;
    int          n_err;
    logic        e0v, esv;

    avalon_mem_responder #(
        .AddrWidth(32), .MemWords(1024), .ReadLatency(2), .StallCycles(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .avs_address(addr0), .avs_byteenable(be0),
        .avs_read(rd0), .avs_write(wr0), .avs_writedata(wd0),
        .avs_waitrequest(wait0), .avs_readdata(rdata0),
        .avs_readdatavalid(rdv0), .avs_response(resp0), .protocol_err_o(perr0)
    );

    avalon_mem_responder #(
        .AddrWidth(32), .MemWords(1024), .ReadLatency(2), .StallCycles(3)
    ) dut_s (
        .clk_i(clk), .rst_i(rst), .avs_address(addrs), .avs_byteenable(bes),
        .avs_read(rds), .avs_write(wrs), .avs_writedata(wds),
        .avs_waitrequest(waits), .avs_readdata(rdatas),
        .avs_readdatavalid(rdvs), .avs_response(resps), .protocol_err_o(perrs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Zero-stall scoreboard: readdatavalid must appear exactly when due
    always @(negedge clk) begin
        e0v = (q0.size() > 0) && (q0[0].due == cyc);
        check("rdv0", {31'b0, rdv0}, {31'b0, e0v});
        if (e0v) begin
            check("rdata0", rdata0, q0[0].data);
            check("resp0", {30'b0, resp0}, {30'b0, q0[0].resp});
            void'(q0.pop_front());
        end
    end

    // Stalled-instance scoreboard
    always @(negedge clk) begin
        esv = (qs.size() > 0) && (qs[0].due == cyc);
        check("rdvs", {31'b0, rdvs}, {31'b0, esv});
        if (esv) begin
            check("rdatas", rdatas, qs[0].data);
            check("resps", {30'b0, resps}, {30'b0, qs[0].resp});
            void'(qs.pop_front());
        end
    end

    // One command on the zero-stall instance; it must be accepted immediately
    task automatic bus0(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; be0 = be;
        if (rd && !wr) begin
            e.data = (a < 1024) ? ref0[a[9:0]] : 32'h0;
            e.resp = (a < 1024) ? 2'b00 : 2'b10;
            e.due  = cyc + 2;
            q0.push_back(e);
        end
        if (wr && (a < 1024)) ref0[a[9:0]] = merge(ref0[a[9:0]], d, be);
        @(negedge clk);
        check("wait0", {31'b0, wait0}, 32'h0);
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    // One command on the stalled instance, counting waitrequest cycles
    task automatic bus_s(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int exp_waits);
        exp_t e;
        int   nw;
        bit   done;
        rds = rd; wrs = wr; addrs = a; wds = d; bes = 4'hF;
        nw = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (waits) begin
                nw++;
            end else begin
                done = 1'b1;
                if (rd && !wr) begin
                    e.data = refs[a[9:0]];
                    e.resp = 2'b00;
                    e.due  = cyc + 2;
                    qs.push_back(e);
                end
                if (wr) refs[a[9:0]] = d;
            end
            @(posedge clk); #1;
        end
        check("stall_waits", nw, exp_waits);
        rds = 1'b0; wrs = 1'b0;
    endtask

    task automatic idle(input int n);
        rd0 = 1'b0; wr0 = 1'b0; rds = 1'b0; wrs = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Reset drops all in-flight reads, so the scoreboards are emptied too
    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        qs.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0; be0 = 0;
        rds = 0; wrs = 0; addrs = 0; wds = 0; bes = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_wait0", {31'b0, wait0}, 32'h0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_resp0", {30'b0, resp0}, 32'h0);
        check("rst_perr0", {31'b0, perr0}, 32'h0);
        check("rst_perrs", {31'b0, perrs}, 32'h0);

        // Write then read on the following cycle
        bus0(0, 1, 5, 32'hDEADBEEF, 4'hF);
        bus0(1, 0, 5, 0, 4'h0);
        idle(3);

        // Back-to-back pipelined reads
        for (int i = 0; i < 4; i++) bus0(0, 1, i, i, 4'hF);
        for (int i = 0; i < 4; i++) bus0(1, 0, i, 0, 4'h0);
        idle(3);

        // Byte lanes
        bus0(0, 1, 3, 32'h11223344, 4'hF);
        bus0(0, 1, 3, 32'hAABBCCDD, 4'b0101);
        bus0(1, 0, 3, 0, 4'h0);
        idle(3);

        // Out-of-range read and dropped out-of-range write
        bus0(1, 0, 1024, 0, 4'h0);
        bus0(0, 1, 976, 32'hCAFE0976, 4'hF);
        bus0(0, 1, 2000, 32'hFFFFFFFF, 4'hF);
        bus0(1, 0, 976, 0, 4'h0);
        bus0(1, 0, 32'h8000_0005, 0, 4'h0);
        idle(4);

        // Stall timing with StallCycles=3
        bus_s(0, 1, 9, 32'h5A5A0009, 3);
        bus_s(1, 0, 9, 0, 3);
        idle(4);
        check("perrs_clean", {31'b0, perrs}, 32'h0);

        // Command withdrawn during a stall
        rds = 1'b1; addrs = 9;
        @(posedge clk); #1;
        rds = 1'b0;
        @(posedge clk); #1;
        check("perrs_drop", {31'b0, perrs}, 32'h1);

        // Reset one cycle after a read is accepted: no readdatavalid
        bus0(1, 0, 5, 0, 4'h0);
        do_reset();
        idle(4);
        check("perr0_after_rst", {31'b0, perr0}, 32'h0);
        check("perrs_after_rst", {31'b0, perrs}, 32'h0);

        // Simultaneous read and write: write lands, flag sticks
        bus0(1, 1, 7, 32'h0BADF00D, 4'hF);
        check("perr0_dual", {31'b0, perr0}, 32'h1);
        bus0(1, 0, 7, 0, 4'h0);
        idle(4);
        check("perr0_sticky", {31'b0, perr0}, 32'h1);
        do_reset();
        check("perr0_cleared", {31'b0, perr0}, 32'h0);

        // Memory survives reset
        bus0(1, 0, 5, 0, 4'h0);
        idle(4);

        check("q0_drained", q0.size(), 32'h0);
        check("qs_drained", qs.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_avalon_mem_responder
`default_nettype wire
